// File: rtl/rv32i_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_ctrl_pkg
// Brief    : Shared run-control state encoding and default timing constants.
// Revision : 1.0  initial release
// ============================================================================
package rv32i_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALT     = 2'd2,
        ST_STEP     = 2'd3
    } run_state_e;

    localparam int RATE_DIV_DEF = 64;
    localparam int DEBOUNCE_DEF = 500000;
    localparam int RST_HOLD_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-FF synchronizer, stability counter and press pulse for an
//            active-low pushbutton.
// Revision : 1.0  initial release
// ============================================================================
module key_debounce
    import rv32i_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse,
    output logic level
);

    localparam int              CW        = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0]   c_CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta  <= key_n;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                // Accept the new level; only a 1->0 acceptance is a press.
                r_stable <= r_sync;
                r_cnt    <= '0;
                r_press  <= r_stable & ~r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press_pulse = r_press;
    assign level       = r_stable;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Clock-enable sequencer for the RV32I core: reset hold, free-run,
//            halt, single-step and executed-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module cpu_run_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int RATE_DIV     = RATE_DIV_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_DEF,
    parameter int RST_HOLD     = RST_HOLD_DEF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_key_n,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state_o
);

    localparam int            DW         = $clog2(RATE_DIV);
    localparam int            HW         = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DW-1:0] c_DIV_MAX  = DW'(RATE_DIV - 1);
    localparam logic [HW-1:0] c_HOLD_MAX = HW'(RST_HOLD - 1);

    run_state_e       r_state;
    logic             r_run_meta;
    logic             r_run_s;
    logic             r_run_q;
    logic [DW-1:0]    r_div;
    logic [HW-1:0]    r_hold;
    logic [CNT_W-1:0] r_cnt;

    logic             w_step_pulse;
    logic             w_run_rise;
    logic             w_tick;
    logic             w_ce;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key (
        .clk         (clk),
        .rst         (rst),
        .key_n       (step_key_n),
        .press_pulse (w_step_pulse),
        .level       ()
    );

    assign w_run_rise = r_run_s & ~r_run_q;
    assign w_tick     = (r_state == ST_RUN) && (r_div == c_DIV_MAX);
    // A halt request in a tick cycle swallows that tick; a falling switch does not.
    assign w_ce       = (w_tick && !halt_req) || (r_state == ST_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RST_HOLD;
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_run_q    <= 1'b0;
            r_div      <= '0;
            r_hold     <= '0;
            r_cnt      <= '0;
        end else begin
            r_run_meta <= run_sw;
            r_run_s    <= r_run_meta;
            r_run_q    <= r_run_s;
            if (w_ce) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                ST_RST_HOLD: begin
                    r_div <= '0;
                    if (r_hold == c_HOLD_MAX) begin
                        r_hold  <= '0;
                        r_state <= r_run_s ? ST_RUN : ST_HALT;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt_req || !r_run_s) begin
                        r_state <= ST_HALT;
                        r_div   <= '0;
                    end else begin
                        r_div <= (r_div == c_DIV_MAX) ? '0 : r_div + 1'b1;
                    end
                end
                ST_HALT: begin
                    r_div <= '0;
                    // Resuming needs a fresh switch edge so a core halt sticks.
                    if (w_step_pulse) begin
                        r_state <= ST_STEP;
                    end else if (w_run_rise && !halt_req) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign cpu_ce    = w_ce;
    assign cpu_rst   = (r_state == ST_RST_HOLD);
    assign cycle_cnt = r_cnt;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run-control sequencer for the RV32I pipeline core. It replaces the free-running clock divider with a single-clock design: the core is clocked at clk and advanced only when cpu_ce is high. It also provides post-reset hold, free-run at a programmable rate, halt on core request, single-step from a debounced pushbutton, and an executed-cycle counter for LED/debug display.

Parameters:
RATE_DIV, 64, clk cycles per cpu_ce pulse in RUN; legal range 2 or more.
DEBOUNCE_CYC, 500000, cycles a synced key level must stay stable before it is accepted (10 ms at 50 MHz).
RST_HOLD, 16, cycles cpu_rst stays asserted after rst releases; legal range 1 or more.
CNT_W, 32, width of cycle_cnt.

Ports:
clk  in  1  system clock (CLOCK_50 domain); the only clock.
rst  in  1  synchronous, active-high reset.
run_sw  in  1  asynchronous slide switch; 1 requests free-run.
step_key_n  in  1  asynchronous pushbutton, active-low; a press requests one step.
halt_req  in  1  from core, clk domain; 1-cycle or level halt request (e.g. ebreak).
cpu_ce  out  1  clock enable to the pipeline; the core advances one stage-cycle per high cycle.
cpu_rst  out  1  active-high reset to the pipeline.
cycle_cnt  out  CNT_W  number of cpu_ce pulses issued since reset.
state_o  out  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset (rst=1 at a clk edge) forces: state=RST_HOLD, cpu_rst=1, cpu_ce=0, cycle_cnt=0, div_cnt=0, hold_cnt=0, sync flops=idle (run_sw chain 0, key chain 1), debounced key=1, run_q=0.
- run_sw and step_key_n each pass through a 2-FF synchronizer before use.
- Debounce (key): while synced != stable, cnt increments. When cnt == DEBOUNCE_CYC-1, stable <= synced and cnt <= 0. When synced == stable, cnt <= 0.
- step_pulse: 1-cycle high on the stable 1->0 transition (press only; release ignored).
- run_rise = run_s & ~run_q; run_q is run_s delayed one cycle.
- FSM states and encodings: RST_HOLD=0, RUN=1, HALT=2, STEP=3. state_o = state.
- RST_HOLD: cpu_rst=1, cpu_ce=0, hold_cnt++. When hold_cnt == RST_HOLD-1, go to RUN if run_s=1, else HALT. cpu_rst is decoded from state, so it is low from the first cycle in the new state.
- RUN: div_cnt counts 0..RATE_DIV-1 and wraps to 0.
  - cpu_ce = (div_cnt == RATE_DIV-1) & ~halt_req, combinational from registers and halt_req.
  - The first cpu_ce pulse occurs RATE_DIV cycles after entering RUN.
  - halt_req=1 goes to HALT and clears div_cnt. If halt_req is high in the same cycle as a tick, that cpu_ce is suppressed.
  - run_s=0 goes to HALT and clears div_cnt. If run_s falls in a tick cycle, the tick still fires.
  - step_pulse is ignored in RUN.
- HALT: cpu_ce=0, div_cnt held at 0.
  - step_pulse goes to STEP.
  - run_rise with halt_req=0 goes to RUN. If both occur in the same cycle, step has priority.
  - Level run_s=1 alone never leaves HALT: after a core halt, the switch must be toggled to resume.
- STEP: cpu_ce=1 for exactly this one cycle, then unconditionally to HALT. halt_req and run_s are ignored here.
- cycle_cnt increments on every cycle with cpu_ce=1 and wraps from 2^CNT_W-1 to 0.
- rst mid-operation (any state, any counter value) returns to the reset values on the next edge. A pending debounce is discarded.
- No combinational path from step_key_n or run_sw to any output.

Decomposition:
- Package rv32i_ctrl_pkg holds the run_state_e enum (2-bit, encodings above) and the default constants RATE_DIV_DEF, DEBOUNCE_DEF, RST_HOLD_DEF.
- Sub-module key_debounce contains the 2-FF sync, stable counter and press-pulse output. It is parameterized by DEBOUNCE_CYC and has ports clk, rst, key_n, press_pulse, level.
- run_sw uses a plain 2-FF sync inside cpu_run_ctrl.
- Top-level integration: RISCV-level top instantiates cpu_run_ctrl and feeds the pipeline clk=CLOCK_50, ce=cpu_ce, rst=cpu_rst.

Test Plan:
All scenarios use RATE_DIV=4, DEBOUNCE_CYC=8, RST_HOLD=3, CNT_W=8 unless noted.
- Reset hold, run_sw=1 held: release rst at cycle 0 -> cpu_rst=1 for cycles 0-2, state RUN from cycle 3, cpu_ce high at cycles 6, 10, 14 only, cycle_cnt=3 at cycle 15.
- Core halt: in RUN, pulse halt_req in a tick cycle -> no cpu_ce that cycle, state_o=2 next cycle, cycle_cnt frozen. Toggle run_sw 0->1 -> RUN resumes, first cpu_ce 4 cycles after re-entry plus sync latency.
- Single-step: run_sw=0 in HALT, hold step_key_n=0 for 20 cycles -> exactly one cpu_ce pulse, 2+8+1 cycles after the press edge, via state 3 for one cycle, cycle_cnt +1. Then release -> no pulse.
- Bounce rejection: toggle step_key_n every 3 cycles for 30 cycles, then settle at 1 -> zero step_pulse, zero cpu_ce.
- Wrap and priority: preload via 256 run ticks -> cycle_cnt wraps 255->0. In HALT, apply step_pulse and run_rise in the same cycle -> STEP taken, then HALT.
- Reset mid-debounce and mid-RUN: assert rst when div_cnt=2 and debounce cnt=5 -> next cycle all outputs at reset values, state_o=0, cpu_rst=1.
